// File: rtl/filter_gen_ctrl.sv
// filter_gen_ctrl: control unit for the line-buffer KxK window generator.
// Walks a raster pixel stream and produces line-buffer write/address/row-pointer
// controls, the window shift enable and a strided window-valid flag with its
// linear output index.
// Optional feature: define FILTER_GEN_STALL_CNT_EN to add the stall_cnt output.
//
// Handshake: a pixel is transferred on every rising edge where
// pix_valid & pix_ready are both high (accept). pix_ready depends only on the
// FSM state, never on pix_valid. With pix_valid low all counters hold.
module filter_gen_ctrl #(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int ADDR_W = 8,
  localparam int PTR_W = (K > 2) ? $clog2(K - 1) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic              lb_wr_en,
  output logic              shift_en,
  output logic [ADDR_W-1:0] lb_addr,
  output logic [PTR_W-1:0]  lb_row_ptr,
  output logic              win_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
`ifdef FILTER_GEN_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic [1:0]        state
);

  localparam int ROW_W = $clog2(IMG_H);
  localparam int PH_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [ADDR_W-1:0] COL_LAST  = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] COL_WIN0  = ADDR_W'(K - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0]  ROW_WIN0  = ROW_W'(K - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(K - 2);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(STRIDE - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] col_q;
  logic [ROW_W-1:0]  row_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [PH_W-1:0]   col_ph_q;
  logic [PH_W-1:0]   row_ph_q;
  logic [ADDR_W-1:0] win_cnt_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic              win_valid_q;

  logic accept;
  logic col_last;
  logic row_last;
  logic last_pix;
  logic col_ok;
  logic row_ok;
  logic eligible;
  logic frame_start;

  // Handshake and position decode for the pixel currently offered.
  always_comb begin
    pix_ready   = (state_q == S_FILL) || (state_q == S_RUN);
    accept      = pix_valid & pix_ready;
    col_last    = (col_q == COL_LAST);
    row_last    = (row_q == ROW_LAST);
    last_pix    = col_last & row_last;
    col_ok      = (col_q >= COL_WIN0);
    row_ok      = (row_q >= ROW_WIN0);
    // Phase counters replace (row-(K-1)) % STRIDE and (col-(K-1)) % STRIDE.
    eligible    = row_ok & col_ok & (row_ph_q == '0) & (col_ph_q == '0);
    frame_start = (state_q == S_IDLE) & start;
  end

  // Next-state logic; the final pixel takes priority over the FILL->RUN move.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_FILL;
      S_FILL: begin
        if (accept && last_pix)      state_d = S_DONE;
        else if (accept && eligible) state_d = S_RUN;
      end
      S_RUN:  if (accept && last_pix) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Raster position, row-rotation pointer and stride phase counters.
  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      col_q    <= '0;
      row_q    <= '0;
      ptr_q    <= '0;
      col_ph_q <= '0;
      row_ph_q <= '0;
    end else if (accept) begin
      if (col_last) begin
        col_q    <= '0;
        row_q    <= row_last ? '0 : row_q + 1'b1;
        ptr_q    <= (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
        col_ph_q <= '0;
        if (row_ok) row_ph_q <= (row_ph_q == PH_LAST) ? '0 : row_ph_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
        if (col_ok) col_ph_q <= (col_ph_q == PH_LAST) ? '0 : col_ph_q + 1'b1;
      end
    end
  end

  // Window flag one cycle after an eligible accept; out_addr holds the index
  // of the most recent window until the next one arrives.
  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      win_valid_q <= 1'b0;
      win_cnt_q   <= '0;
      out_addr_q  <= '0;
    end else begin
      win_valid_q <= accept & eligible;
      if (accept && eligible) begin
        out_addr_q <= win_cnt_q;
        win_cnt_q  <= win_cnt_q + 1'b1;
      end
    end
  end

`ifdef FILTER_GEN_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of busy cycles with no upstream pixel; held after done.
  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      stall_cnt_q <= '0;
    end else if (pix_ready && !pix_valid && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

  assign lb_wr_en   = accept;
  assign shift_en   = accept;
  assign lb_addr    = col_q;
  assign lb_row_ptr = ptr_q;
  assign win_valid  = win_valid_q;
  assign out_addr   = out_addr_q;
  assign busy       = pix_ready;
  assign done       = (state_q == S_DONE);
  assign state      = state_q;

endmodule

// File: tb/tb_filter_gen_ctrl.sv
// Directed bench for filter_gen_ctrl: two 8x8 K=3 instances (stride 1 and 2)
// driven by a table of frame scenarios plus a reset-state check.
module tb_filter_gen_ctrl;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int KK = 3;

  typedef struct {
    int sel;        // 0: stride-1 instance, 1: stride-2 instance
    int mode;       // pix_valid pattern: 0 always, 1 toggle, 2 five stalls
    int rst_at;     // pixel index at which rst hits (-1 none)
    int glitch;     // pulse start mid-RUN and during DONE
    int exp_win;    // expected win_valid pulses
    int exp_last;   // expected out_addr after the frame
    int exp_cycles; // busy cycles until done
    int exp_stalls; // expected stall_cnt at done
  } vec_t;

  // clock/reset block
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]       start_s, pv_s, rdy_s, wr_s, sh_s, wv_s, busy_s, done_s, ptr_s;
  logic [1:0][7:0]  lba_s, oa_s;
  logic [1:0][1:0]  st_s;
  logic [1:0][15:0] stall_s;

  int n_cmp = 0;
  int n_bad = 0;

  filter_gen_ctrl #(.IMG_W(W), .IMG_H(H), .K(KK), .STRIDE(1), .ADDR_W(8)) dut_s1 (
    .clk(clk), .rst(rst), .start(start_s[0]), .pix_valid(pv_s[0]),
    .pix_ready(rdy_s[0]), .lb_wr_en(wr_s[0]), .shift_en(sh_s[0]),
    .lb_addr(lba_s[0]), .lb_row_ptr(ptr_s[0:0]), .win_valid(wv_s[0]),
    .out_addr(oa_s[0]), .busy(busy_s[0]), .done(done_s[0]),
`ifdef FILTER_GEN_STALL_CNT_EN
    .stall_cnt(stall_s[0]),
`endif
    .state(st_s[0])
  );

  filter_gen_ctrl #(.IMG_W(W), .IMG_H(H), .K(KK), .STRIDE(2), .ADDR_W(8)) dut_s2 (
    .clk(clk), .rst(rst), .start(start_s[1]), .pix_valid(pv_s[1]),
    .pix_ready(rdy_s[1]), .lb_wr_en(wr_s[1]), .shift_en(sh_s[1]),
    .lb_addr(lba_s[1]), .lb_row_ptr(ptr_s[1:1]), .win_valid(wv_s[1]),
    .out_addr(oa_s[1]), .busy(busy_s[1]), .done(done_s[1]),
`ifdef FILTER_GEN_STALL_CNT_EN
    .stall_cnt(stall_s[1]),
`endif
    .state(st_s[1])
  );

`ifndef FILTER_GEN_STALL_CNT_EN
  assign stall_s = '0;
`endif

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic pat(input int mode, input int k);
    case (mode)
      1:       return (k % 2) == 0;
      2:       return !(k == 3 || k == 10 || k == 11 || k == 40 || k == 60);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic elig(input int r, input int c, input int s);
    return (r >= KK - 1) && (c >= KK - 1) && ((r - (KK - 1)) % s == 0) && ((c - (KK - 1)) % s == 0);
  endfunction

  task automatic check_reset_vals(input int sel);
    check("rst_state", st_s[sel], 0);
    check("rst_ready", rdy_s[sel], 0);
    check("rst_win_valid", wv_s[sel], 0);
    check("rst_done", done_s[sel], 0);
    check("rst_out_addr", oa_s[sel], 0);
    check("rst_lb_addr", lba_s[sel], 0);
    check("rst_row_ptr", ptr_s[sel], 0);
    check("rst_busy", busy_s[sel], 0);
  endtask

  // driver + per-cycle checks for one frame scenario
  task automatic run_frame(input vec_t v);
    int   p, k, s, dut_wins, exp_wins;
    logic vld, el, was_rst;
    s = (v.sel == 1) ? 2 : 1;
    start_s[v.sel] = 1'b1;
    @(posedge clk); #1;
    start_s[v.sel] = 1'b0;
    check("start_state", st_s[v.sel], 1);
`ifdef FILTER_GEN_STALL_CNT_EN
    check("stall_cleared", stall_s[v.sel], 0);
`endif
    p = 0; k = 0; dut_wins = 0; exp_wins = 0; was_rst = 1'b0;
    while (p < W * H && k < 400 && !was_rst) begin
      vld = pat(v.mode, k);
      pv_s[v.sel] = vld;
      if (v.glitch != 0 && k == 25) start_s[v.sel] = 1'b1;
      if (p == v.rst_at && vld) rst = 1'b1;
      #1;
      check("state", st_s[v.sel], (p > 18) ? 2 : 1);
      check("lb_addr", lba_s[v.sel], p % W);
      check("row_ptr", ptr_s[v.sel], (p / W) % (KK - 1));
      check("lb_wr_en", wr_s[v.sel], vld);
      check("shift_en", sh_s[v.sel], vld);
      check("pix_ready", rdy_s[v.sel], 1);
      check("busy", busy_s[v.sel], 1);
      @(posedge clk); #1;
      start_s[v.sel] = 1'b0;
      if (rst) begin
        rst = 1'b0;
        was_rst = 1'b1;
        pv_s[v.sel] = 1'b0;
        check_reset_vals(v.sel);
      end else begin
        el = vld && elig(p / W, p % W, s);
        check("win_valid", wv_s[v.sel], el);
        if (wv_s[v.sel]) dut_wins++;
        if (el) begin
          check("out_addr", oa_s[v.sel], exp_wins);
          exp_wins++;
        end
        check("done", done_s[v.sel], vld && (p == W * H - 1));
        if (vld) p++;
        k++;
      end
    end
    pv_s[v.sel] = 1'b0;
    if (!was_rst) begin
      check("frame_cycles", k, v.exp_cycles);
      check("win_count", dut_wins, v.exp_win);
      check("last_out_addr", oa_s[v.sel], v.exp_last);
      check("done_state", st_s[v.sel], 3);
`ifdef FILTER_GEN_STALL_CNT_EN
      check("stall_at_done", stall_s[v.sel], v.exp_stalls);
`endif
      if (v.glitch != 0) start_s[v.sel] = 1'b1;
      @(posedge clk); #1;
      start_s[v.sel] = 1'b0;
      check("back_idle", st_s[v.sel], 0);
      check("done_low", done_s[v.sel], 0);
      check("idle_ready", rdy_s[v.sel], 0);
      check("addr_hold", oa_s[v.sel], v.exp_last);
`ifdef FILTER_GEN_STALL_CNT_EN
      check("stall_hold", stall_s[v.sel], v.exp_stalls);
`endif
    end
  endtask

  vec_t tbl[8];

  initial begin
    //          sel mode rst glt win last cyc stalls
    tbl[0] = '{0, 0, -1, 0, 36, 35, 64, 0};
    tbl[1] = '{1, 0, -1, 0,  9,  8, 64, 0};
    tbl[2] = '{0, 1, -1, 0, 36, 35, 127, 63};
    tbl[3] = '{0, 0, -1, 1, 36, 35, 64, 0};
    tbl[4] = '{0, 0, 30, 0,  0,  0,  0, 0};
    tbl[5] = '{0, 0, -1, 0, 36, 35, 64, 0};
    tbl[6] = '{0, 2, -1, 0, 36, 35, 69, 5};
    tbl[7] = '{1, 1, -1, 0,  9,  8, 127, 63};

    rst = 1'b1;
    start_s = '0;
    pv_s = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals(0);
    check_reset_vals(1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_hold", st_s[0], 0);

    for (int i = 0; i < 8; i++) run_frame(tbl[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
